// File: rtl/ft_pkg.sv
// Shared types and constants for the lockstep fault-injection stage.
package ft_pkg;

  // Campaign controller states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_INJECT = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } ft_inj_state_e;

  // Width of every campaign counter.
  localparam int FT_CNT_W = 8;

  // Galois feedback mask for the 32-bit LFSR.
  localparam logic [31:0] FT_LFSR_POLY = 32'h8020_0003;

  // Default seed used when the integrator does not override it.
  localparam logic [31:0] FT_LFSR_SEED = 32'hACE1_2024;

  // Observation bundle: current controller state and raw LFSR contents.
  typedef struct packed {
    ft_inj_state_e state;
    logic [31:0]   lfsr;
  } ft_dbg_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [FT_CNT_W-1:0] sat_inc(input logic [FT_CNT_W-1:0] v);
    logic [FT_CNT_W-1:0] r;
    if (v == {FT_CNT_W{1'b1}}) r = v;
    else                       r = v + {{(FT_CNT_W-1){1'b0}}, 1'b1};
    return r;
  endfunction

endpackage

// File: rtl/ft_lfsr.sv
// 32-bit Galois LFSR that advances only when enabled; a zero seed is
// replaced by 1 so the register can never lock up in the all-zero state.
module ft_lfsr #(
  parameter logic [31:0] SEED = 32'hACE1_2024,
  parameter logic [31:0] POLY = 32'h8020_0003
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en,
  output logic [31:0] q
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [31:0] q_next;

  // Right-shifting Galois step: the bit shifted out selects the feedback mask.
  always_comb begin
    q_next = {1'b0, q[31:1]};
    if (q[0]) q_next = q_next ^ POLY;
  end

  // State register; holds its value whenever en is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  q <= SEED_EFF;
    else if (en)  q <= q_next;
  end

endmodule

// File: rtl/ft_fault_injector.sv
// On-chip single-bit fault injector for the lockstep comparison path.
// Flips one bit of one selected bus for one cycle, then watches error_i to
// classify the fault as detected or missed.
//
// Control semantics: arm_i is a level, not a handshake. While it is high a
// campaign runs; when it drops in any busy state the controller returns to
// IDLE on the next edge with counters frozen. force_inject_i is a single-cycle
// request sampled only in ARMED; it carries force_target_i/force_bit_i with it.
module ft_fault_injector
  import ft_pkg::*;
#(
  parameter int          NUM_TARGETS    = 8,
  parameter int          MAX_INJECT     = 10,
  parameter int          DETECT_TIMEOUT = 64,
  parameter logic [31:0] PC_LIMIT       = 32'h100,
  parameter logic [31:0] PROB_THRESH    = 32'd3,
  parameter logic [31:0] LFSR_SEED      = FT_LFSR_SEED,
  localparam int         TGT_W          = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         arm_i,
  input  logic                         force_inject_i,
  input  logic [TGT_W-1:0]             force_target_i,
  input  logic [4:0]                   force_bit_i,
  input  logic [31:0]                  pc_i,
  input  logic                         error_i,
  input  logic [NUM_TARGETS-1:0][31:0] sig_i,
  output logic [NUM_TARGETS-1:0][31:0] sig_o,
  output logic                         inject_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [FT_CNT_W-1:0]          inj_cnt_o,
  output logic [FT_CNT_W-1:0]          det_cnt_o,
  output logic [FT_CNT_W-1:0]          miss_cnt_o,
  output logic [FT_CNT_W-1:0]          spur_cnt_o,
  output ft_dbg_t                      dbg_o
);

  localparam int TMR_W = (DETECT_TIMEOUT > 1) ? $clog2(DETECT_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]    TMO_LAST = TMR_W'(DETECT_TIMEOUT - 1);
  localparam logic [FT_CNT_W-1:0] INJ_MAX  = FT_CNT_W'(MAX_INJECT);

  ft_inj_state_e       state_q, state_d;
  logic [TGT_W-1:0]    tgt_q, tgt_d;
  logic [4:0]          bit_q, bit_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [FT_CNT_W-1:0] inj_q, inj_d;
  logic [FT_CNT_W-1:0] det_q, det_d;
  logic [FT_CNT_W-1:0] miss_q, miss_d;
  logic [FT_CNT_W-1:0] spur_q, spur_d;
  logic [FT_CNT_W-1:0] inj_next;
  logic                error_q;
  logic                err_rise;
  logic                rand_hit;
  logic [31:0]         lfsr_q;

  // Random source; only consumes steps while waiting for an injection slot.
  ft_lfsr #(
    .SEED (LFSR_SEED),
    .POLY (FT_LFSR_POLY)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en     (state_q == ST_ARMED),
    .q      (lfsr_q)
  );

  assign err_rise = error_i & ~error_q;
  assign rand_hit = ({27'd0, lfsr_q[4:0]} < PROB_THRESH) && (pc_i < PC_LIMIT);
  assign inj_next = sat_inc(inj_q);

  // Next-state, fault selection and counter updates.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    bit_d   = bit_q;
    timer_d = timer_q;
    inj_d   = inj_q;
    det_d   = det_q;
    miss_d  = miss_q;
    spur_d  = spur_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arm_i) begin
          inj_d   = '0;
          det_d   = '0;
          miss_d  = '0;
          spur_d  = '0;
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (!arm_i) begin
          state_d = ST_IDLE;
        end else begin
          // Any error seen while no fault is outstanding is spurious.
          if (err_rise) spur_d = sat_inc(spur_q);
          if (force_inject_i) begin
            tgt_d   = force_target_i;
            bit_d   = force_bit_i;
            state_d = ST_INJECT;
          end else if (rand_hit) begin
            tgt_d   = lfsr_q[8 +: TGT_W];
            bit_d   = lfsr_q[20:16];
            state_d = ST_INJECT;
          end
        end
      end

      ST_INJECT: begin
        if (!arm_i) begin
          state_d = ST_IDLE;
        end else begin
          inj_d   = inj_next;
          timer_d = '0;
          if (err_rise) begin
            det_d   = sat_inc(det_q);
            state_d = (inj_next == INJ_MAX) ? ST_DONE : ST_ARMED;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (!arm_i) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (err_rise) begin
            det_d   = sat_inc(det_q);
            state_d = (inj_q == INJ_MAX) ? ST_DONE : ST_ARMED;
          end else if (timer_q == TMO_LAST) begin
            miss_d  = sat_inc(miss_q);
            state_d = (inj_q == INJ_MAX) ? ST_DONE : ST_ARMED;
          end
        end
      end

      ST_DONE: begin
        if (!arm_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Controller, fault-selection and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      bit_q   <= '0;
      timer_q <= '0;
      inj_q   <= '0;
      det_q   <= '0;
      miss_q  <= '0;
      spur_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      bit_q   <= bit_d;
      timer_q <= timer_d;
      inj_q   <= inj_d;
      det_q   <= det_d;
      miss_q  <= miss_d;
      spur_q  <= spur_d;
      error_q <= error_i;
    end
  end

  // Clean buses pass straight through; only the INJECT cycle alters one bit.
  always_comb begin
    sig_o = sig_i;
    if (state_q == ST_INJECT) begin
      sig_o[tgt_q] = sig_i[tgt_q] ^ (32'd1 << bit_q);
    end
  end

  assign inject_o   = (state_q == ST_INJECT);
  assign busy_o     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o     = (state_q == ST_DONE);
  assign inj_cnt_o  = inj_q;
  assign det_cnt_o  = det_q;
  assign miss_cnt_o = miss_q;
  assign spur_cnt_o = spur_q;
  assign dbg_o      = '{state: state_q, lfsr: lfsr_q};

endmodule

// File: tb/tb_ft_fault_injector.sv
// Directed bench for ft_fault_injector: reset, directed detect/miss,
// spurious errors, arm drop, reset mid-campaign, PC gating and two seeded
// random campaigns whose fault sequences must match.
module tb_ft_fault_injector;
  import ft_pkg::*;

  logic                clk_i;
  logic                rst_ni;
  logic                arm_i;
  logic                force_inject_i;
  logic [2:0]          force_target_i;
  logic [4:0]          force_bit_i;
  logic [31:0]         pc_i;
  logic                error_i;
  logic [7:0][31:0]    sig_i;
  logic [7:0][31:0]    sig_o;
  logic                inject_o;
  logic                busy_o;
  logic                done_o;
  logic [7:0]          inj_cnt_o;
  logic [7:0]          det_cnt_o;
  logic [7:0]          miss_cnt_o;
  logic [7:0]          spur_cnt_o;
  ft_dbg_t             dbg_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard: fault positions (target*32+bit) from the first random run.
  logic [7:0] exp_q[$];

  ft_fault_injector dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .arm_i          (arm_i),
    .force_inject_i (force_inject_i),
    .force_target_i (force_target_i),
    .force_bit_i    (force_bit_i),
    .pc_i           (pc_i),
    .error_i        (error_i),
    .sig_i          (sig_i),
    .sig_o          (sig_o),
    .inject_o       (inject_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .inj_cnt_o      (inj_cnt_o),
    .det_cnt_o      (det_cnt_o),
    .miss_cnt_o     (miss_cnt_o),
    .spur_cnt_o     (spur_cnt_o),
    .dbg_o          (dbg_o)
  );

  // Clock and watchdog.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver helpers.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [7:0] inj, input logic [7:0] det,
                           input logic [7:0] miss, input logic [7:0] spur);
    check({tag, "_inj"},  inj_cnt_o,  inj);
    check({tag, "_det"},  det_cnt_o,  det);
    check({tag, "_miss"}, miss_cnt_o, miss);
    check({tag, "_spur"}, spur_cnt_o, spur);
  endtask

  logic [7:0][31:0] exp_sig;
  logic [255:0]     diff;
  logic [7:0]       idx;
  logic             last_inj;
  int               seen;

  initial begin
    rst_ni = 1'b0; arm_i = 1'b0; force_inject_i = 1'b0; force_target_i = '0;
    force_bit_i = '0; pc_i = 32'h200; error_i = 1'b0;
    for (int i = 0; i < 8; i++) sig_i[i] = 32'hA5C3_0F00 | i;
    sig_i[2] = 32'h0000_0000;
    repeat (2) step();
    rst_ni = 1'b1;

    // Reset values.
    check("rst_state",  dbg_o.state, ST_IDLE);
    check("rst_inject", inject_o, 1'b0);
    check("rst_busy",   busy_o,   1'b0);
    check("rst_done",   done_o,   1'b0);
    check("rst_sig",    sig_o,    sig_i);
    check_cnt("rst", 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) step();
    check("idle_lfsr_held", dbg_o.lfsr, 32'hACE1_2024);

    // Directed injection on bus 2 bit 5, detected three cycles later.
    arm_i = 1'b1;
    step();
    check("armed_state", dbg_o.state, ST_ARMED);
    check("armed_busy",  busy_o, 1'b1);
    force_inject_i = 1'b1; force_target_i = 3'd2; force_bit_i = 5'd5;
    step();
    force_inject_i = 1'b0;
    exp_sig = sig_i;
    exp_sig[2] = 32'h0000_0020;
    check("inj_inject", inject_o, 1'b1);
    check("inj_sig",    sig_o, exp_sig);
    check("inj_lfsr",   dbg_o.lfsr, 32'h5670_9012);
    step();
    check("wait_state", dbg_o.state, ST_WAIT);
    check("wait_sig",   sig_o, sig_i);
    check("wait_inj",   inj_cnt_o, 8'd1);
    step();
    step();
    error_i = 1'b1;
    step();
    error_i = 1'b0;
    check("det_state", dbg_o.state, ST_ARMED);
    check_cnt("det", 8'd1, 8'd1, 8'd0, 8'd0);

    // Directed injection with no error: miss after 64 WAIT cycles.
    force_inject_i = 1'b1; force_target_i = 3'd7; force_bit_i = 5'd31;
    step();
    force_inject_i = 1'b0;
    exp_sig = sig_i;
    exp_sig[7] = sig_i[7] ^ 32'h8000_0000;
    check("miss_inj_sig", sig_o, exp_sig);
    step();
    repeat (63) step();
    check("miss_last_wait", dbg_o.state, ST_WAIT);
    check("miss_not_yet",   miss_cnt_o, 8'd0);
    step();
    check("miss_state", dbg_o.state, ST_ARMED);
    check_cnt("miss", 8'd2, 8'd1, 8'd1, 8'd0);

    // Spurious error while ARMED.
    error_i = 1'b1;
    step();
    error_i = 1'b0;
    step();
    check("spur_state", dbg_o.state, ST_ARMED);
    check_cnt("spur", 8'd2, 8'd1, 8'd1, 8'd1);

    // Arm drop in WAIT: IDLE next edge, counters held.
    force_inject_i = 1'b1; force_target_i = 3'd0; force_bit_i = 5'd0;
    step();
    force_inject_i = 1'b0;
    step();
    check("drop_in_wait", dbg_o.state, ST_WAIT);
    arm_i = 1'b0;
    step();
    check("drop_state", dbg_o.state, ST_IDLE);
    check("drop_busy",  busy_o, 1'b0);
    check_cnt("drop", 8'd3, 8'd1, 8'd1, 8'd1);

    // Re-arm clears counters; reset during INJECT removes the fault at once.
    arm_i = 1'b1;
    step();
    check_cnt("rearm", 8'd0, 8'd0, 8'd0, 8'd0);
    force_inject_i = 1'b1; force_target_i = 3'd5; force_bit_i = 5'd31;
    step();
    force_inject_i = 1'b0;
    exp_sig = sig_i;
    exp_sig[5] = sig_i[5] ^ 32'h8000_0000;
    check("rinj_sig", sig_o, exp_sig);
    rst_ni = 1'b0;
    #2;
    check("rinj_sig_clean", sig_o, sig_i);
    check("rinj_inject",    inject_o, 1'b0);
    check("rinj_state",     dbg_o.state, ST_IDLE);
    step();
    rst_ni = 1'b1;

    // Reset mid-WAIT.
    step();
    force_inject_i = 1'b1; force_target_i = 3'd1; force_bit_i = 5'd0;
    step();
    force_inject_i = 1'b0;
    step();
    step();
    check("rwait_state", dbg_o.state, ST_WAIT);
    check("rwait_inj",   inj_cnt_o, 8'd1);
    rst_ni = 1'b0;
    #2;
    check_cnt("rwait", 8'd0, 8'd0, 8'd0, 8'd0);
    check("rwait_inject", inject_o, 1'b0);
    check("rwait_sig",    sig_o, sig_i);
    check("rwait_lfsr",   dbg_o.lfsr, 32'hACE1_2024);
    step();
    rst_ni = 1'b1;
    arm_i  = 1'b0;
    step();

    // PC gating: no injection above PC_LIMIT.
    pc_i  = 32'h200;
    arm_i = 1'b1;
    step();
    seen = 0;
    for (int c = 0; c < 10000; c++) begin
      step();
      if (inject_o) seen++;
    end
    check("pcgate_seen",  seen, 0);
    check("pcgate_inj",   inj_cnt_o, 8'd0);
    check("pcgate_state", dbg_o.state, ST_ARMED);
    arm_i = 1'b0;
    step();

    // Two seeded random campaigns; error_i follows inject_o one cycle later.
    pc_i = 32'h40;
    for (int run = 0; run < 2; run++) begin
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      arm_i = 1'b1;
      last_inj = 1'b0;
      seen = 0;
      for (int c = 0; c < 5000 && !done_o; c++) begin
        step();
        error_i  = last_inj;
        last_inj = inject_o;
        if (inject_o) begin
          seen++;
          diff = sig_o ^ sig_i;
          check("rand_onebit", $countones(diff), 1);
          idx = '0;
          for (int i = 0; i < 256; i++) if (diff[i]) idx = 8'(i);
          if (run == 0) exp_q.push_back(idx);
          else if (exp_q.size() == 0) check("rand_seq_extra", idx, 9'h100);
          else check("rand_seq", idx, exp_q.pop_front());
        end
      end
      error_i = 1'b0;
      check("rand_done", done_o, 1'b1);
      check("rand_seen", seen, 10);
      check_cnt("rand", 8'd10, 8'd10, 8'd0, 8'd0);
      step();
      check("rand_done_hold", dbg_o.state, ST_DONE);
      arm_i = 1'b0;
      step();
      check("rand_idle", dbg_o.state, ST_IDLE);
      check("rand_done_low", done_o, 1'b0);
    end
    check("rand_seq_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ft_fault_injector.md
# ft_fault_injector

Synthesizable fault-injection stage for the lockstep SoC: it sits between the memory/core boundary signals (instruction and data buses of both cores) and the cores' comparison logic. It flips single bits on one selected 32-bit bus for one cycle, then watches the fault-tolerance module's `error` output to classify each fault as detected or missed. It replaces bench-side `force`/`release` injection with repeatable, seed-driven on-chip injection.

## Interface
- `NUM_TARGETS`, default 8: number of 32-bit injectable buses; must be a power of two.
- `MAX_INJECT`, default 10: injections per campaign before DONE.
- `DETECT_TIMEOUT`, default 64: cycles to wait for `error_i` after an injection.
- `PC_LIMIT`, default 32'h100: inject only while `pc_i < PC_LIMIT`.
- `PROB_THRESH`, default 3: inject when `lfsr[4:0] < PROB_THRESH`, i.e. a probability of PROB_THRESH/32 per cycle.
- `LFSR_SEED`, default 32'hACE1_2024: a seed of 0 is replaced by 1.
- `clk_i`, in, 1: the single clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `arm_i`, in, 1: level; high runs a campaign.
- `force_inject_i`, in, 1: directed injection request; used in ARMED only.
- `force_target_i`, in, log2(NUM_TARGETS): target bus for a directed injection.
- `force_bit_i`, in, 5: bit to flip for a directed injection.
- `pc_i`, in, 32: core_0 instruction address.
- `error_i`, in, 1: mismatch flag from the FT module.
- `sig_i`, in, NUM_TARGETS x 32: clean buses.
- `sig_o`, out, NUM_TARGETS x 32: buses passed through, or with the fault applied.
- `inject_o`, out, 1: high during the injection cycle.
- `busy_o`, out, 1: state is not IDLE and not DONE.
- `done_o`, out, 1: state is DONE.
- `inj_cnt_o`, `det_cnt_o`, `miss_cnt_o`, `spur_cnt_o`, out, 8 each: campaign counters.

## Operation
- States: IDLE, ARMED, INJECT, WAIT, DONE.
- **IDLE:**
  - On `arm_i` = 1: clear all counters, go to ARMED.
  - The LFSR holds its value.
- **ARMED:**
  - The LFSR advances every cycle.
  - If `force_inject_i`=1, latch target = `force_target_i` and bit = `force_bit_i`. Otherwise, if `lfsr[4:0] < PROB_THRESH` and `pc_i < PC_LIMIT`, latch target = `lfsr[8 +: log2 NUM_TARGETS]` and bit = `lfsr[20:16]`.
  - Either case goes to INJECT.
  - An `error_i` rising edge here increments `spur_cnt`.
- **INJECT:**
  - Lasts exactly 1 cycle.
  - `sig_o[target] = sig_i[target] ^ (1 << bit)`; `inject_o` = 1; `inj_cnt` +1.
  - An `error_i` rising edge in this same cycle counts as detected: `det_cnt` +1, go to ARMED or DONE.
  - Otherwise go to WAIT with the timer at 0.
- **WAIT:**
  - All buses pass through; the timer increments.
  - An `error_i` rising edge gives `det_cnt` +1.
  - If the timer reaches DETECT_TIMEOUT-1 with no edge, `miss_cnt` +1.
  - Either way, go to DONE if `inj_cnt == MAX_INJECT`, else to ARMED.
- **DONE:** hold all counters; go to IDLE when `arm_i` = 0.
- **Rising edge of `error_i`:** `error_i & ~error_q`, where `error_q` is a registered copy.
- **`arm_i` falls in ARMED, INJECT or WAIT:** go to IDLE on the next edge. Counters keep their values; an outstanding injection is counted neither detected nor missed.
- **Counters:** saturate at 255.
- **LFSR:** 32-bit Galois, polynomial 0x8020_0003.
- **Outside INJECT:** `sig_o = sig_i` combinationally.

## Timing
- **Reset:**
  - State IDLE; LFSR = seed; all counters 0; `error_q` 0.
  - `inject_o`, `busy_o`, `done_o` are 0; `sig_o = sig_i`.
- **Reset asserted mid-campaign:** immediate return to the reset values. No fault is held on `sig_o`.
- **`sig_o` path:** combinational from `sig_i` plus the registered target, bit and state; no added latency on clean buses.
- **Injection decision:**
  - Random injection: the decision is made in ARMED cycle N; the fault appears in cycle N+1.
  - Directed injection: `force_inject_i` sampled high in cycle N causes the flip in cycle N+1.
- **Detection window:** the INJECT cycle plus DETECT_TIMEOUT WAIT cycles.
- **`done_o`:** rises the cycle after the final classification.

## Structure
- Package `ft_pkg`:
  - `ft_inj_state_e` enum.
  - `FT_CNT_W` = 8.
  - LFSR polynomial constant.
- Sub-module `ft_lfsr`: parameters seed and polynomial; inputs `en` and `clk_i`/`rst_ni`; output 32-bit `q`.
- Top level: FSM, counters, edge detector, XOR mux.

## Test plan
- **Reset mid-WAIT:** all counters 0, `inject_o`=0, `sig_o` equals `sig_i` in the same cycle.
- **Directed injection, detected:**
  - Stimulus: arm, force target 2, bit 5, with `sig_i[2]` = 32'h0000_0000.
  - In the INJECT cycle `sig_o[2]` = 32'h0000_0020 and the other buses are unchanged.
  - `error_i` pulses 3 cycles later: `det_cnt`=1, `miss_cnt`=0.
- **Directed injection, no `error_i`:** `miss_cnt`=1 after exactly 64 WAIT cycles; return to ARMED.
- **Random campaign** with `error_i` tied to `inject_o` delayed 1 cycle and `pc_i`=0x40:
  - Reaches DONE with `inj_cnt`=10, `det_cnt`=10.
  - Two runs with the same seed give identical target/bit sequences.
- **PC gating:** with `pc_i`=0x200 and no force, no injection for 10000 cycles; `inj_cnt`=0.
- **Spurious error:** an `error_i` pulse in ARMED gives `spur_cnt`=1; `det_cnt` is unchanged. Dropping `arm_i` in WAIT gives IDLE on the next edge with counters held.
